// File: rtl/data_mem.sv
// Word-addressed 1024 x 32 data memory for the MEM stage: synchronous write, read gated by MemRead.
// Define DATAMEM_RDREG_EN for a registered (1-cycle latency) read port; the default read is combinational.
module data_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_MemWrite,
  input  logic              i_MemRead,
  input  logic [ADDR_W-1:0] i_Address,
  input  logic [DATA_W-1:0] i_Write_Data,
  output logic [DATA_W-1:0] o_Read_Data
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic              in_range;
  logic [DATA_W-1:0] rd_word;

  // Addresses beyond DEPTH neither write nor read anything.
  assign in_range = ({1'b0, i_Address} < DEPTH_W);
  assign rd_word  = in_range ? mem[i_Address] : '0;

  // Reset wins over a write on the same edge and clears every word.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (i_MemWrite && in_range) begin
      mem[i_Address] <= i_Write_Data;
    end
  end

`ifdef DATAMEM_RDREG_EN
  // Sampled before the write lands, so a same-address access captures the old word.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_Read_Data <= '0;
    end else if (i_MemRead) begin
      o_Read_Data <= rd_word;
    end else begin
      o_Read_Data <= '0;
    end
  end
`else
  assign o_Read_Data = (i_RST || !i_MemRead) ? '0 : rd_word;
`endif

endmodule

// File: tb/tb_data_mem.sv
// Directed, table-driven bench for data_mem (default combinational read build).
module tb_data_mem;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;

  int checks;
  int errors;

  typedef struct {
    logic              rst;
    logic              we;
    logic              re;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] exp;
  } vec_t;

  vec_t vecs [0:18];

  data_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(1024)) dut (
    .i_CLK        (clk),
    .i_RST        (rst),
    .i_MemWrite   (mem_write),
    .i_MemRead    (mem_read),
    .i_Address    (address),
    .i_Write_Data (write_data),
    .o_Read_Data  (read_data)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic we, input logic re,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    rst        = r;
    mem_write  = we;
    mem_read   = re;
    address    = a;
    write_data = wd;
  endtask

  task automatic check(input string name, input logic [DATA_W-1:0] exp);
    checks++;
    if (read_data !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, read_data, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, 1'b0, 1'b0, '0, '0);

    // Each row is driven after a falling edge and checked before the next rising edge,
    // so exp is the pre-edge value; the row's write (if any) lands on that rising edge.
    //           rst   we    re    addr  wdata          exp
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 10'd6,    32'd0,          32'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 10'd6,    32'd0,          32'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 10'd9,    32'd0,          32'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 10'd6,    32'd0,          32'd0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 10'd6,    32'd1023,       32'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 10'd6,    32'd0,          32'd1023};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 10'd9,    32'd0,          32'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 10'd6,    32'd23,         32'd1023};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 10'd6,    32'd0,          32'd1023};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 10'd6,    32'd9,          32'd1023};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 10'd6,    32'd0,          32'd9};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 10'd1023, 32'h0000_A5A5,  32'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 10'd1023, 32'd0,          32'h0000_A5A5};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 10'd0,    32'd5,          32'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 10'd0,    32'd0,          32'd5};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 10'd6,    32'hDEAD_BEEF,  32'd0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 10'd6,    32'd0,          32'd0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 10'd1023, 32'd0,          32'd0};
    vecs[18] = '{1'b0, 1'b0, 1'b1, 10'd0,    32'd0,          32'd0};

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Load addr 6 = 77 and addr 9 = 0x99 for the mid-cycle sequences.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 10'd6, 32'd77);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 10'd9, 32'h99);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 10'd6, 32'd0);
    #1;
    check("mid_addr6", 32'd77);
    #1 address = 10'd9;
    #1;
    check("mid_addr9", 32'h99);
    #1 mem_read = 1'b0;
    #1;
    check("mid_read_off", 32'd0);

    // Reset raised and dropped between edges only forces the output; no clear happens.
    #1 begin mem_read = 1'b1; rst = 1'b1; end
    #1;
    check("mid_rst_force", 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_release", 32'h99);

    // Write edge with data changing while MemWrite is low does not disturb contents.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 10'd9, 32'hFFFF_FFFF);
    @(negedge clk);
    #1;
    check("no_write_hold", 32'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
